// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer with run-time word length (1..MAX_WIDTH),
// selectable bit order, running parity and a sticky overrun flag.
// Frame configuration is latched in IDLE and frozen until the next IDLE.
module param_deserializer #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DESER_EN,
  input  logic                 SAMPLED_BIT,
  input  logic                 CLR,
  input  logic [CNT_W-1:0]     DATA_LEN,
  input  logic                 LSB_FIRST,
  output logic [MAX_WIDTH-1:0] P_DATA,
  output logic                 DATA_VALID,
  output logic [CNT_W-1:0]     BIT_CNT,
  output logic                 PAR_BIT,
  output logic                 OVERRUN
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       len_q,   len_d;
  logic                   lsb_q,   lsb_d;
  logic [MAX_WIDTH-1:0]   data_q,  data_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   par_q,   par_d;
  logic                   ovr_q,   ovr_d;

  logic [CNT_W-1:0]       din_len;
  logic [CNT_W-1:0]       cur_len;
  logic                   cur_lsb;
  logic [CNT_W-1:0]       bit_idx;
  logic [CNT_W-1:0]       cnt_inc;

  // Clamp requested length and pick the live (IDLE) or latched configuration.
  // In IDLE the first capture must already use the incoming configuration,
  // so the inputs bypass the latch for that cycle.
  always_comb begin
    din_len = DATA_LEN;
    if (DATA_LEN == '0 || DATA_LEN > MAX_LEN) begin
      din_len = MAX_LEN;
    end
    cur_len = (state_q == IDLE) ? din_len   : len_q;
    cur_lsb = (state_q == IDLE) ? LSB_FIRST : lsb_q;
    cnt_inc = cnt_q + CNT_W'(1);
    bit_idx = cur_lsb ? cnt_q : (cur_len - CNT_W'(1) - cnt_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lsb_d   = lsb_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ovr_d   = ovr_q;

    if (CLR) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
      par_d   = 1'b0;
      ovr_d   = 1'b0;
      if (state_q == IDLE) begin
        len_d = din_len;
        lsb_d = LSB_FIRST;
      end
    end else begin
      unique case (state_q)
        IDLE, SHIFT: begin
          if (DESER_EN) begin
            len_d = cur_len;
            lsb_d = cur_lsb;
            for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
              if (CNT_W'(i) == bit_idx) begin
                data_d[i] = SAMPLED_BIT;
              end
            end
            cnt_d = cnt_inc;
            par_d = par_q ^ SAMPLED_BIT;
            if (cnt_inc == cur_len) begin
              state_d = FULL;
              valid_d = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        FULL: begin
          if (DESER_EN) begin
            ovr_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= MAX_LEN;
      lsb_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lsb_q   <= lsb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
    end
  end

  assign P_DATA     = data_q;
  assign DATA_VALID = valid_q;
  assign BIT_CNT    = cnt_q;
  assign PAR_BIT    = par_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Self-checking bench for param_deserializer: directed scenarios plus a
// randomized run, all compared against a queue-based frame model.
module tb_param_deserializer;

  localparam int MW = 9;
  localparam int CW = 4;
  localparam int OW = MW + CW + 3;

  logic          CLK;
  logic          RST;
  logic          DESER_EN;
  logic          SAMPLED_BIT;
  logic          CLR;
  logic [CW-1:0] DATA_LEN;
  logic          LSB_FIRST;
  logic [MW-1:0] P_DATA;
  logic          DATA_VALID;
  logic [CW-1:0] BIT_CNT;
  logic          PAR_BIT;
  logic          OVERRUN;

  logic [OW-1:0] dut_out;
  assign dut_out = {P_DATA, DATA_VALID, BIT_CNT, PAR_BIT, OVERRUN};

  int errors = 0;
  int checks = 0;

  // Reference model: bits captured in the current frame, frame config, flags.
  bit q_bits[$];
  int m_len = MW;
  bit m_lsb = 1'b1;
  bit m_ovr = 1'b0;
  bit m_valid = 1'b0;

  param_deserializer #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DESER_EN   (DESER_EN),
    .SAMPLED_BIT(SAMPLED_BIT),
    .CLR        (CLR),
    .DATA_LEN   (DATA_LEN),
    .LSB_FIRST  (LSB_FIRST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .BIT_CNT    (BIT_CNT),
    .PAR_BIT    (PAR_BIT),
    .OVERRUN    (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [OW-1:0] model_out();
    logic [MW-1:0] w;
    bit p;
    w = '0;
    p = 1'b0;
    foreach (q_bits[i]) begin
      if (m_lsb) w[i] = q_bits[i];
      else       w[m_len-1-i] = q_bits[i];
      p ^= q_bits[i];
    end
    return {w, m_valid, CW'(q_bits.size()), p, m_ovr};
  endfunction

  task automatic model_reset();
    q_bits.delete();
    m_ovr   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input bit clr, input bit en, input bit b,
                            input int dlen, input bit lsb);
    m_valid = 1'b0;
    if (clr) begin
      q_bits.delete();
      m_ovr = 1'b0;
    end else if (en) begin
      if (q_bits.size() == 0) begin
        m_len = (dlen >= 1 && dlen <= MW) ? dlen : MW;
        m_lsb = lsb;
      end
      if (q_bits.size() < m_len) begin
        q_bits.push_back(b);
        if (q_bits.size() == m_len) m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic tick(input bit clr, input bit en, input bit b,
                      input int dlen, input bit lsb);
    @(negedge CLK);
    CLR         = clr;
    DESER_EN    = en;
    SAMPLED_BIT = b;
    DATA_LEN    = CW'(dlen);
    LSB_FIRST   = lsb;
    @(posedge CLK);
    model_step(clr, en, b, dlen, lsb);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; CLR = 1'b0; DESER_EN = 1'b0; SAMPLED_BIT = 1'b0;
    DATA_LEN = '0; LSB_FIRST = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dut_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", dut_out);
    end
    @(negedge CLK);
    RST = 1'b1;
    tick(0, 0, 0, 9, 1);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", dut_out, model_out());
    end
  endtask

  task automatic test_lsb8();
    bit seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    tick(1, 0, 0, 8, 1);
    foreach (seq[i]) begin
      tick(0, 1, seq[i], 8, 1);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL lsb8_bit%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (P_DATA !== 9'h04D || DATA_VALID !== 1'b1 || BIT_CNT !== 4'd8 || PAR_BIT !== 1'b0) begin
      errors++;
      $display("FAIL lsb8_word: got data=%h v=%b cnt=%0d par=%b want 04d 1 8 0",
               P_DATA, DATA_VALID, BIT_CNT, PAR_BIT);
    end
    tick(0, 0, 0, 8, 1);
    checks++;
    if (DATA_VALID !== 1'b0 || P_DATA !== 9'h04D) begin
      errors++;
      $display("FAIL lsb8_pulse: got v=%b data=%h want 0 04d", DATA_VALID, P_DATA);
    end
  endtask

  task automatic test_msb5();
    bit seq[5] = '{1, 0, 0, 1, 1};
    tick(1, 0, 0, 5, 0);
    foreach (seq[i]) begin
      tick(0, 1, seq[i], 5, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL msb5_bit%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (P_DATA !== 9'h013 || PAR_BIT !== 1'b1 || P_DATA[8:5] !== 4'h0 || DATA_VALID !== 1'b1) begin
      errors++;
      $display("FAIL msb5_word: got data=%h par=%b v=%b want 013 1 1", P_DATA, PAR_BIT, DATA_VALID);
    end
  endtask

  task automatic test_overrun();
    logic [OW-1:0] e;
    logic [MW-1:0] held;
    bit lsb;
    lsb = 1'($urandom_range(0, 1));
    tick(1, 0, 0, 8, lsb);
    for (int i = 0; i < 8; i++) tick(0, 1, 1'($urandom_range(0, 1)), 8, lsb);
    e = model_out();
    held = e[OW-1 -: MW];
    tick(0, 1, 1, 8, lsb);
    checks++;
    if (OVERRUN !== 1'b1 || P_DATA !== held || DATA_VALID !== 1'b0 || BIT_CNT !== 4'd8) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b data=%h v=%b cnt=%0d want 1 %h 0 8",
               OVERRUN, P_DATA, DATA_VALID, BIT_CNT, held);
    end
    tick(0, 0, 0, 8, lsb);
    checks++;
    if (dut_out !== model_out() || OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %h want %h", dut_out, model_out());
    end
    tick(1, 0, 0, 8, lsb);
    checks++;
    if (dut_out !== '0) begin
      errors++;
      $display("FAIL overrun_clear: got %h want 0", dut_out);
    end
  endtask

  task automatic test_gaps_abort();
    tick(1, 0, 0, 9, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1'($urandom_range(0, 1)), 9, 1);
      tick(0, 0, 1, 9, 1);
      tick(0, 0, 0, 9, 1);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL gap_bit%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    tick(1, 1, 1, 9, 1);
    checks++;
    if (BIT_CNT !== '0 || P_DATA !== '0 || DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort: got cnt=%0d data=%h v=%b want 0 0 0", BIT_CNT, P_DATA, DATA_VALID);
    end
    tick(0, 0, 0, 9, 1);
    checks++;
    if (dut_out !== '0) begin
      errors++;
      $display("FAIL abort_idle: got %h want 0", dut_out);
    end
  endtask

  task automatic test_clamp();
    int dl[2] = '{0, 12};
    foreach (dl[k]) begin
      tick(1, 0, 0, dl[k], 1);
      for (int i = 0; i < 8; i++) tick(0, 1, 1'($urandom_range(0, 1)), dl[k], 1);
      checks++;
      if (DATA_VALID !== 1'b0 || BIT_CNT !== 4'd8) begin
        errors++;
        $display("FAIL clamp%0d_early: got v=%b cnt=%0d want 0 8", dl[k], DATA_VALID, BIT_CNT);
      end
      tick(0, 1, 1, dl[k], 1);
      checks++;
      if (dut_out !== model_out() || DATA_VALID !== 1'b1 || BIT_CNT !== 4'd9) begin
        errors++;
        $display("FAIL clamp%0d_done: got %h want %h", dl[k], dut_out, model_out());
      end
    end
    // Start a 9-bit MSB-first frame, then change DATA_LEN and order mid-frame.
    tick(1, 0, 0, 9, 0);
    tick(0, 1, 1, 9, 0);
    tick(0, 1, 0, 9, 0);
    for (int i = 2; i < 9; i++) begin
      tick(0, 1, 1'($urandom_range(0, 1)), 5, 1);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL midchange_bit%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (DATA_VALID !== 1'b1 || BIT_CNT !== 4'd9 || P_DATA[8] !== 1'b1) begin
      errors++;
      $display("FAIL midchange_done: got v=%b cnt=%0d data=%h want 1 9 msb=1",
               DATA_VALID, BIT_CNT, P_DATA);
    end
  endtask

  task automatic test_len1();
    tick(1, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 0);
    checks++;
    if (P_DATA !== 9'h001 || DATA_VALID !== 1'b1 || BIT_CNT !== 4'd1 || PAR_BIT !== 1'b1) begin
      errors++;
      $display("FAIL len1: got data=%h v=%b cnt=%0d par=%b want 001 1 1 1",
               P_DATA, DATA_VALID, BIT_CNT, PAR_BIT);
    end
    tick(0, 1, 0, 1, 0);
    checks++;
    if (dut_out !== model_out() || OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL len1_overrun: got %h want %h", dut_out, model_out());
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 0, 9, 1);
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 9, 1);
    checks++;
    if (BIT_CNT !== 4'd6 || P_DATA !== 9'h03F) begin
      errors++;
      $display("FAIL areset_pre: got cnt=%0d data=%h want 6 03f", BIT_CNT, P_DATA);
    end
    #2;
    RST = 1'b0;
    DESER_EN = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_out !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got %h want 0", dut_out);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    tick(0, 1, 1, 4, 0);
    checks++;
    if (dut_out !== model_out() || BIT_CNT !== 4'd1 || P_DATA !== 9'h008) begin
      errors++;
      $display("FAIL areset_restart: got %h want %h", dut_out, model_out());
    end
  endtask

  task automatic test_random();
    int dlen;
    bit clr, en, b, lsb;
    tick(1, 0, 0, 9, 1);
    for (int c = 0; c < 2000; c++) begin
      clr  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 2) != 0);
      b    = 1'($urandom_range(0, 1));
      dlen = $urandom_range(0, 15);
      lsb  = 1'($urandom_range(0, 1));
      tick(clr, en, b, dlen, lsb);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", c, dut_out, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb8();
    test_msb5();
    test_overrun();
    test_gaps_abort();
    test_clamp();
    test_len1();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 Parameter MAX_WIDTH, default 9: widest supported data word in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 4: width of the bit counter and DATA_LEN, equal to clog2(MAX_WIDTH+1).
REQ-003 Port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port DESER_EN, input, 1 bit: qualifies SAMPLED_BIT as one received data bit this cycle.
REQ-006 Port SAMPLED_BIT, input, 1 bit: bit value to capture.
REQ-007 Port CLR, input, 1 bit: synchronous start-of-frame clear.
REQ-008 Port DATA_LEN, input, CNT_W bits: bits per word, sampled at frame start.
REQ-009 Port LSB_FIRST, input, 1 bit: 1 means the first bit is the LSB; 0 means the first bit is the MSB. Sampled at frame start.
REQ-010 Port P_DATA, output, MAX_WIDTH bits: assembled word, right-justified, with unused upper bits 0.
REQ-011 Port DATA_VALID, output, 1 bit: one-cycle pulse when the word completes.
REQ-012 Port BIT_CNT, output, CNT_W bits: number of bits captured in the current frame.
REQ-013 Port PAR_BIT, output, 1 bit: XOR of all bits captured in the current frame.
REQ-014 Port OVERRUN, output, 1 bit: sticky flag for a bit arriving after the word is complete.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and FULL; all outputs are registered.
REQ-016 In IDLE, the frame configuration SHALL be latched on any cycle with CLR=1, or on DESER_EN=1: effective length and bit order are captured from DATA_LEN and LSB_FIRST.
REQ-017 The effective length SHALL be DATA_LEN when 1 <= DATA_LEN <= MAX_WIDTH; otherwise it is MAX_WIDTH (clamp).
REQ-018 On each cycle with DESER_EN=1 in IDLE or SHIFT, with index k = BIT_CNT, the bit SHALL be written to P_DATA[k] if LSB-first, or to P_DATA[len-1-k] if MSB-first.
REQ-019 Each such capture SHALL also increment BIT_CNT and toggle PAR_BIT if SAMPLED_BIT=1.
REQ-020 P_DATA bits at index >= len SHALL be 0 for the whole frame.
REQ-021 Transitions: IDLE -> SHIFT on the first capture, or directly IDLE -> FULL when len=1.
REQ-022 SHIFT -> FULL on the edge that captures bit len-1.
REQ-023 DATA_VALID SHALL be 1 for exactly the one cycle following that edge; latency from the last DESER_EN to DATA_VALID is 1 clock.
REQ-024 In FULL, P_DATA, BIT_CNT and PAR_BIT SHALL hold.
REQ-025 In FULL, DESER_EN=1 SHALL set OVERRUN and discard the bit; OVERRUN stays 1 until CLR or reset.
REQ-026 CLR=1 in any state SHALL, on the next edge, go to IDLE and zero P_DATA, BIT_CNT, PAR_BIT, OVERRUN and DATA_VALID.
REQ-027 CLR SHALL have priority over DESER_EN in the same cycle; that bit is discarded.
REQ-028 DESER_EN=0 SHALL leave all state unchanged except that DATA_VALID returns to 0.
REQ-029 DATA_LEN and LSB_FIRST changes during SHIFT or FULL SHALL have no effect until the next IDLE.
REQ-030 CLR asserted mid-frame SHALL abandon the partial word with no DATA_VALID pulse.

Reset
REQ-031 RST=0 SHALL immediately, independent of CLK, force IDLE, P_DATA=0, BIT_CNT=0, PAR_BIT=0, DATA_VALID=0 and OVERRUN=0.
REQ-032 After RST deasserts, the first DESER_EN SHALL be treated as bit 0 of a new frame.
REQ-033 The latched length and bit order SHALL reset to MAX_WIDTH and LSB-first.

Verification
REQ-034 LSB-first, len 8: DATA_LEN=8, LSB_FIRST=1, CLR, then serial bits 1,0,1,1,0,0,1,0 -> P_DATA=0x04D, DATA_VALID one cycle after bit 8, BIT_CNT=8, PAR_BIT=0.
REQ-035 MSB-first, len 5: DATA_LEN=5, LSB_FIRST=0, bits 1,0,0,1,1 -> P_DATA=0x013, PAR_BIT=1, P_DATA[8:5]=0.
REQ-036 Overrun: complete a len-8 word, then one extra DESER_EN -> OVERRUN=1, P_DATA unchanged, no second DATA_VALID; CLR -> OVERRUN=0.
REQ-037 Gaps and abort: len 9, 4 bits with DESER_EN gaps, then CLR+DESER_EN in the same cycle -> BIT_CNT=0, P_DATA=0, no DATA_VALID.
REQ-038 Clamp: DATA_LEN=0 or 12 -> word completes after 9 bits; DATA_LEN changed to 5 mid-frame -> still 9 bits.
REQ-039 Async reset: RST=0 pulsed between clock edges at BIT_CNT=6 -> all outputs 0 immediately; next frame starts at bit 0.
